exception_ctrl: RTL and testbench

- Non-critical exception sequencer downstream of the program-error detector.
- Consumes three held requests: program error (progErr plus 3-bit cause code), system call and external interrupt. It also handles rfi.
- For each serviced exception it flushes the pipe, writes SRR0/SRR1/ESR/MSR, redirects fetch to the IVPR/IVOR vector, then pulses ack to the winning source.

---
 rtl/exception_ctrl_pkg.sv | 40 ++++
 rtl/exception_ctrl_exc_priority.sv | 41 ++++
 rtl/exception_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_exception_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg
//   Shared definitions for the non-critical exception sequencer: FSM state
//   encodings, cause codes, grant-vector bit positions and the ESR/MSR bit
//   positions the sequencer writes or clears.
package exception_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SAVE  = 3'd2,
        S_REDIR = 3'd3,
        S_ACK   = 3'd4,
        S_RFI   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_PROG = 2'd1,
        CAUSE_SC   = 2'd2,
        CAUSE_EXT  = 2'd3
    } cause_t;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_PROG = 0;
    localparam int GNT_SC   = 1;
    localparam int GNT_EXT  = 2;
    localparam int GNT_RFI  = 3;

    // ESR program-exception detail bits.
    localparam int ESR_PIL = 27;
    localparam int ESR_PPR = 26;
    localparam int ESR_PTR = 25;

    // MSR bits cleared on exception entry.
    localparam int MSR_EE = 15;
    localparam int MSR_PR = 14;
    localparam int MSR_IS = 5;
    localparam int MSR_DS = 4;

endpackage

// File: rtl/exception_ctrl_exc_priority.sv
// exc_priority
//   Combinational priority encoder for the exception sequencer.
//   Priority: progErr > sysCall > (extInt & MSR.EE & EXT_EN) > rfi.
// Ports:
//   progErr, sysCall, extInt, rfi  in   held request levels
//   msrEE                          in   current MSR[EE]
//   grant                          out  one-hot grant {rfi, ext, sc, prog}
//   cause                          out  cause code of the winning exception
//                                       (CAUSE_NONE for rfi or no request)
module exc_priority
    import exception_ctrl_pkg::*;
#(
    parameter bit EXT_EN = 1'b1
) (
    input  logic       progErr,
    input  logic       sysCall,
    input  logic       extInt,
    input  logic       rfi,
    input  logic       msrEE,
    output logic [3:0] grant,
    output cause_t     cause
);

    always_comb begin
        grant = '0;
        cause = CAUSE_NONE;
        if (progErr) begin
            grant[GNT_PROG] = 1'b1;
            cause           = CAUSE_PROG;
        end else if (sysCall) begin
            grant[GNT_SC] = 1'b1;
            cause         = CAUSE_SC;
        end else if (extInt && msrEE && EXT_EN) begin
            grant[GNT_EXT] = 1'b1;
            cause          = CAUSE_EXT;
        end else if (rfi) begin
            grant[GNT_RFI] = 1'b1;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl
//   Non-critical exception sequencer. Services program error, system call
//   and external interrupt requests (flush, save SRR0/SRR1/ESR/MSR, redirect
//   to IVPR/IVOR vector, ack) and the one-cycle rfi return path.
// Ports:
//   clk, rst                       clock, async active-high reset
//   progErr/progErrCode            program-error request and {illegal,priv,trap}
//   sysCall, extInt, rfi           held requests
//   pcCur, pcNext                  PC of excepting / next instruction
//   MSR_in, SRR0_in, SRR1_in       current SPR values
//   IVPR, IVOR4, IVOR6, IVOR8      vector base / offsets
//   progAck/sysAck/extAck/rfiAck   one-cycle acknowledge pulses
//   flush, busy                    pipe kill, sequence in progress
//   *_we / *_wd                    SPR write enables and data
//   npc_we, npc                    fetch redirect
//   dbgState                       current FSM state for observation
//
// Valid/ready handshake: each request is a level held by its source until
// the matching one-cycle ack; the source must drop it at the edge that ends
// the ack cycle. A request is only looked at while the FSM is idle, so
// requests seen during a sequence simply wait for the next idle cycle.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int DW     = 32,
    parameter bit EXT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          progErr,
    input  logic [2:0]    progErrCode,
    input  logic          sysCall,
    input  logic          extInt,
    input  logic          rfi,
    input  logic [DW-1:0] pcCur,
    input  logic [DW-1:0] pcNext,
    input  logic [DW-1:0] MSR_in,
    input  logic [DW-1:0] SRR0_in,
    input  logic [DW-1:0] SRR1_in,
    input  logic [DW-1:0] IVPR,
    input  logic [DW-1:0] IVOR4,
    input  logic [DW-1:0] IVOR6,
    input  logic [DW-1:0] IVOR8,
    output logic          progAck,
    output logic          sysAck,
    output logic          extAck,
    output logic          rfiAck,
    output logic          flush,
    output logic          busy,
    output logic          SRR0_we,
    output logic          SRR1_we,
    output logic          ESR_we,
    output logic          MSR_we,
    output logic [DW-1:0] SRR0_wd,
    output logic [DW-1:0] SRR1_wd,
    output logic [DW-1:0] ESR_wd,
    output logic [DW-1:0] MSR_wd,
    output logic          npc_we,
    output logic [DW-1:0] npc,
    output logic [2:0]    dbgState
);

    localparam logic [DW-1:0] MSR_CLR_MASK = (DW'(1) << MSR_EE) | (DW'(1) << MSR_PR) |
                                             (DW'(1) << MSR_IS) | (DW'(1) << MSR_DS);

    state_t        state, stateNext;
    logic [3:0]    grant;
    cause_t        cause;
    logic          captureEn;

    cause_t        causeQ;
    logic [DW-1:0] srr0Q, msrQ, esrQ, vecQ;
    logic [DW-1:0] srr0New, esrNew, vecNew;
    logic [11:0]   ivorField;

    logic          progAckNxt, sysAckNxt, extAckNxt, rfiAckNxt;
    logic          flushNxt, busyNxt;
    logic          srr0WeNxt, srr1WeNxt, esrWeNxt, msrWeNxt, npcWeNxt;
    logic [DW-1:0] srr0WdNxt, srr1WdNxt, esrWdNxt, msrWdNxt, npcNxt;

    // Only the vector fields of IVPR/IVORn take part in the target address.
    logic unusedBits;
    assign unusedBits = ^{IVPR[15:0], IVOR4[DW-1:16], IVOR4[3:0],
                          IVOR6[DW-1:16], IVOR6[3:0], IVOR8[DW-1:16], IVOR8[3:0]};

    exc_priority #(.EXT_EN(EXT_EN)) uPrio (
        .progErr (progErr),
        .sysCall (sysCall),
        .extInt  (extInt),
        .rfi     (rfi),
        .msrEE   (MSR_in[MSR_EE]),
        .grant   (grant),
        .cause   (cause)
    );

    // Values captured at the IDLE exit edge.
    always_comb begin
        srr0New = (cause == CAUSE_PROG) ? pcCur : pcNext;
        esrNew  = '0;
        if (cause == CAUSE_PROG) begin
            esrNew[ESR_PIL] = progErrCode[2];
            esrNew[ESR_PPR] = progErrCode[1];
            esrNew[ESR_PTR] = progErrCode[0];
        end
        case (cause)
            CAUSE_PROG: ivorField = IVOR6[15:4];
            CAUSE_SC:   ivorField = IVOR8[15:4];
            default:    ivorField = IVOR4[15:4];
        endcase
        vecNew = {IVPR[DW-1:16], ivorField, 4'b0000};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        captureEn = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant[GNT_PROG] || grant[GNT_SC] || grant[GNT_EXT]) begin
                    stateNext = S_FLUSH;
                    captureEn = 1'b1;
                end else if (grant[GNT_RFI]) begin
                    stateNext = S_RFI;
                end
            end
            S_FLUSH: stateNext = S_SAVE;
            S_SAVE:  stateNext = S_REDIR;
            S_REDIR: stateNext = S_ACK;
            S_ACK:   stateNext = S_IDLE;
            S_RFI:   stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Outputs are registered: decode the state being entered so each output
    // lines up with the cycle the FSM spends in that state.
    always_comb begin
        progAckNxt = 1'b0;
        sysAckNxt  = 1'b0;
        extAckNxt  = 1'b0;
        rfiAckNxt  = 1'b0;
        flushNxt   = 1'b0;
        busyNxt    = 1'b0;
        srr0WeNxt  = 1'b0;
        srr1WeNxt  = 1'b0;
        esrWeNxt   = 1'b0;
        msrWeNxt   = 1'b0;
        npcWeNxt   = 1'b0;
        srr0WdNxt  = '0;
        srr1WdNxt  = '0;
        esrWdNxt   = '0;
        msrWdNxt   = '0;
        npcNxt     = '0;
        case (stateNext)
            S_FLUSH: begin
                flushNxt = 1'b1;
                busyNxt  = 1'b1;
            end
            S_SAVE: begin
                busyNxt   = 1'b1;
                srr0WeNxt = 1'b1;
                srr0WdNxt = srr0Q;
                srr1WeNxt = 1'b1;
                srr1WdNxt = msrQ;
                msrWeNxt  = 1'b1;
                msrWdNxt  = msrQ & ~MSR_CLR_MASK;
                if (causeQ == CAUSE_PROG) begin
                    esrWeNxt = 1'b1;
                    esrWdNxt = esrQ;
                end
            end
            S_REDIR: begin
                busyNxt  = 1'b1;
                npcWeNxt = 1'b1;
                npcNxt   = vecQ;
            end
            S_ACK: begin
                busyNxt    = 1'b1;
                progAckNxt = (causeQ == CAUSE_PROG);
                sysAckNxt  = (causeQ == CAUSE_SC);
                extAckNxt  = (causeQ == CAUSE_EXT);
            end
            S_RFI: begin
                busyNxt   = 1'b1;
                flushNxt  = 1'b1;
                msrWeNxt  = 1'b1;
                msrWdNxt  = SRR1_in;
                npcWeNxt  = 1'b1;
                npcNxt    = SRR0_in & ~DW'(3);
                rfiAckNxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            causeQ <= CAUSE_NONE;
            srr0Q  <= '0;
            msrQ   <= '0;
            esrQ   <= '0;
            vecQ   <= '0;
        end else if (captureEn) begin
            causeQ <= cause;
            srr0Q  <= srr0New;
            msrQ   <= MSR_in;
            esrQ   <= esrNew;
            vecQ   <= vecNew;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            progAck <= 1'b0;
            sysAck  <= 1'b0;
            extAck  <= 1'b0;
            rfiAck  <= 1'b0;
            flush   <= 1'b0;
            busy    <= 1'b0;
            SRR0_we <= 1'b0;
            SRR1_we <= 1'b0;
            ESR_we  <= 1'b0;
            MSR_we  <= 1'b0;
            npc_we  <= 1'b0;
            SRR0_wd <= '0;
            SRR1_wd <= '0;
            ESR_wd  <= '0;
            MSR_wd  <= '0;
            npc     <= '0;
        end else begin
            progAck <= progAckNxt;
            sysAck  <= sysAckNxt;
            extAck  <= extAckNxt;
            rfiAck  <= rfiAckNxt;
            flush   <= flushNxt;
            busy    <= busyNxt;
            SRR0_we <= srr0WeNxt;
            SRR1_we <= srr1WeNxt;
            ESR_we  <= esrWeNxt;
            MSR_we  <= msrWeNxt;
            npc_we  <= npcWeNxt;
            SRR0_wd <= srr0WdNxt;
            SRR1_wd <= srr1WdNxt;
            ESR_wd  <= esrWdNxt;
            MSR_wd  <= msrWdNxt;
            npc     <= npcNxt;
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl
//   Self-checking bench for exception_ctrl. Every cycle with any strobe high
//   is a "beat"; expected beats (tagged with the cycle they must appear in)
//   are queued by a reference model when stimulus is applied and compared by
//   an independent monitor. Cycles without strobes must be all-zero.
module tb_exception_ctrl;

    localparam int DW = 32;
    localparam int CW = 11;
    localparam int BW = 32 + CW + 5 * DW;

    // ctl bit layout of a beat
    localparam logic [CW-1:0] C_BUSY  = 11'b100_0000_0000;
    localparam logic [CW-1:0] C_FLUSH = 11'b010_0000_0000;
    localparam logic [CW-1:0] C_S0WE  = 11'b001_0000_0000;
    localparam logic [CW-1:0] C_S1WE  = 11'b000_1000_0000;
    localparam logic [CW-1:0] C_ESRWE = 11'b000_0100_0000;
    localparam logic [CW-1:0] C_MSRWE = 11'b000_0010_0000;
    localparam logic [CW-1:0] C_NPCWE = 11'b000_0001_0000;
    localparam logic [CW-1:0] C_PACK  = 11'b000_0000_1000;
    localparam logic [CW-1:0] C_SACK  = 11'b000_0000_0100;
    localparam logic [CW-1:0] C_EACK  = 11'b000_0000_0010;
    localparam logic [CW-1:0] C_RACK  = 11'b000_0000_0001;

    logic          clk, rst;
    logic          progErr, sysCall, extInt, rfi;
    logic [2:0]    progErrCode;
    logic [DW-1:0] pcCur, pcNext, MSR_in, SRR0_in, SRR1_in, IVPR, IVOR4, IVOR6, IVOR8;
    logic          progAck, sysAck, extAck, rfiAck, flush, busy;
    logic          SRR0_we, SRR1_we, ESR_we, MSR_we, npc_we;
    logic [DW-1:0] SRR0_wd, SRR1_wd, ESR_wd, MSR_wd, npc;
    logic [2:0]    dbgState;

    exception_ctrl #(.DW(DW), .EXT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .progErr(progErr), .progErrCode(progErrCode), .sysCall(sysCall),
        .extInt(extInt), .rfi(rfi), .pcCur(pcCur), .pcNext(pcNext),
        .MSR_in(MSR_in), .SRR0_in(SRR0_in), .SRR1_in(SRR1_in), .IVPR(IVPR),
        .IVOR4(IVOR4), .IVOR6(IVOR6), .IVOR8(IVOR8),
        .progAck(progAck), .sysAck(sysAck), .extAck(extAck), .rfiAck(rfiAck),
        .flush(flush), .busy(busy),
        .SRR0_we(SRR0_we), .SRR1_we(SRR1_we), .ESR_we(ESR_we), .MSR_we(MSR_we),
        .SRR0_wd(SRR0_wd), .SRR1_wd(SRR1_wd), .ESR_wd(ESR_wd), .MSR_wd(MSR_wd),
        .npc_we(npc_we), .npc(npc), .dbgState(dbgState)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [BW-1:0] mk(input int c, input logic [CW-1:0] ctl,
                                          input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                          input logic [DW-1:0] esr, input logic [DW-1:0] msr,
                                          input logic [DW-1:0] np);
        logic [31:0] cv;
        cv = c;
        return {cv, ctl, s0, s1, esr, msr, np};
    endfunction

    function automatic logic [BW-1:0] observed(input int c);
        logic [CW-1:0] ctl;
        ctl = {busy, flush, SRR0_we, SRR1_we, ESR_we, MSR_we, npc_we,
               progAck, sysAck, extAck, rfiAck};
        return mk(c, ctl, SRR0_wd, SRR1_wd, ESR_wd, MSR_wd, npc);
    endfunction

    // Monitor: compares every non-idle cycle against the next expected beat.
    logic [BW-1:0] mon_obs, mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            mon_obs = observed(cyc);
            if (mon_obs[BW-33:BW-32-CW] == '0) begin
                checks++;
                if (mon_obs[BW-33:0] != '0) begin
                    errors++;
                    $display("FAIL idle_zero cyc=%0d got=%h expected=0", cyc, mon_obs[BW-33:0]);
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat cyc=%0d got=%h expected=none", cyc, mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (mon_obs !== mon_exp) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got=%h expected=%h", cyc, mon_obs, mon_exp);
                end
            end
        end
    end

    // Request sources: drop the request just after seeing its ack.
    always @(negedge clk) begin
        if (!rst && (progAck || sysAck || extAck || rfiAck)) begin
            automatic logic p = progAck, s = sysAck, e = extAck, r = rfiAck;
            #1;
            if (p) progErr = 1'b0;
            if (s) sysCall = 1'b0;
            if (e) extInt = 1'b0;
            if (r) rfi = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // Expected beats of one exception sequence starting in cycle t.
    task automatic push_exc(input int kind, input int t);
        logic [DW-1:0] s0, esr, iv, vec, msrNew;
        logic [CW-1:0] ack;
        s0     = (kind == 0) ? pcCur : pcNext;
        esr    = (kind == 0) ? (DW'(progErrCode) << 25) : '0;
        iv     = (kind == 0) ? IVOR6 : (kind == 1) ? IVOR8 : IVOR4;
        vec    = (IVPR & 32'hFFFF_0000) | (iv & 32'h0000_FFF0);
        msrNew = MSR_in & ~32'h0000_C030;
        ack    = (kind == 0) ? C_PACK : (kind == 1) ? C_SACK : C_EACK;
        exp_q.push_back(mk(t, C_BUSY | C_FLUSH, '0, '0, '0, '0, '0));
        exp_q.push_back(mk(t + 1, C_BUSY | C_S0WE | C_S1WE | C_MSRWE | ((kind == 0) ? C_ESRWE : '0),
                           s0, MSR_in, esr, msrNew, '0));
        exp_q.push_back(mk(t + 2, C_BUSY | C_NPCWE, '0, '0, '0, '0, vec));
        exp_q.push_back(mk(t + 3, C_BUSY | ack, '0, '0, '0, '0, '0));
    endtask

    // Requests are in place in cycle c0 with the controller idle: service them
    // one by one in priority order; each exception takes 4 busy cycles plus one
    // idle cycle, rfi takes 1 busy cycle plus one idle cycle.
    task automatic add_services(input int c0);
        bit p, s, e, r;
        int t;
        p = progErr;
        s = sysCall;
        e = extInt && MSR_in[15];
        r = rfi;
        t = c0 + 1;
        forever begin
            if (p) begin
                push_exc(0, t); t += 5; p = 0;
            end else if (s) begin
                push_exc(1, t); t += 5; s = 0;
            end else if (e) begin
                push_exc(2, t); t += 5; e = 0;
            end else if (r) begin
                exp_q.push_back(mk(t, C_BUSY | C_FLUSH | C_MSRWE | C_NPCWE | C_RACK,
                                   '0, '0, '0, SRR1_in, SRR0_in & ~32'h3));
                t += 2; r = 0;
            end else begin
                break;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ctx(input logic [DW-1:0] pc, input logic [DW-1:0] pn,
                           input logic [DW-1:0] msr, input logic [DW-1:0] ivpr,
                           input logic [DW-1:0] iv4, input logic [DW-1:0] iv6,
                           input logic [DW-1:0] iv8);
        pcCur = pc; pcNext = pn; MSR_in = msr; IVPR = ivpr;
        IVOR4 = iv4; IVOR6 = iv6; IVOR8 = iv8;
    endtask

    task automatic apply(input bit p, input logic [2:0] code, input bit s,
                         input bit e, input bit r);
        @(negedge clk);
        #1;
        progErrCode = code;
        progErr = p; sysCall = s; extInt = e; rfi = r;
        add_services(cyc);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout got=%0d pending beats expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        progErr = 0; sysCall = 0; extInt = 0; rfi = 0;
    endtask

    task automatic check_all_zero(input string name);
        logic [BW-33:0] v;
        v = observed(0);
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s got=%h expected=0", name, v);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        rst = 1'b1;
        progErr = 0; sysCall = 0; extInt = 0; rfi = 0; progErrCode = '0;
        set_ctx('0, '0, '0, '0, '0, '0, '0);
        SRR0_in = '0; SRR1_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        #1 rst = 1'b0;

        // program error, trap bits 100 -> ESR PIL
        set_ctx(32'h100, 32'h104, 32'h0, 32'hFFFF_0000, 32'h400, 32'h700, 32'h900);
        apply(1, 3'b100, 0, 0, 0);
        drain(50);

        // system call
        set_ctx(32'h200, 32'h204, 32'h0000_C030, 32'hFFFF_0000, 32'h400, 32'h700, 32'h900);
        apply(0, 3'b000, 1, 0, 0);
        drain(50);

        // external interrupt masked by EE=0, then enabled
        set_ctx(32'h300, 32'h304, 32'h0, 32'hFFFF_0000, 32'h450, 32'h700, 32'h900);
        apply(0, 3'b000, 0, 1, 0);
        repeat (20) @(negedge clk);
        #1 MSR_in = 32'h0000_8000;
        add_services(cyc);
        drain(50);

        // all three together: prog, then sc, then ext
        set_ctx(32'h400, 32'h404, 32'h0000_8022, 32'h1234_0000, 32'h4A0, 32'h6B0, 32'h8C0);
        apply(1, 3'b010, 1, 1, 0);
        drain(80);

        // rfi
        SRR0_in = 32'h303; SRR1_in = 32'h8000;
        apply(0, 3'b000, 0, 0, 1);
        drain(20);

        // code 000 and all code bits set
        apply(1, 3'b000, 0, 0, 0);
        drain(50);
        apply(1, 3'b111, 0, 0, 0);
        drain(50);

        // reset during REDIR abandons the sequence; held progErr re-serviced
        set_ctx(32'h500, 32'h504, 32'h0000_4010, 32'hABCD_0000, 32'h400, 32'h770, 32'h900);
        apply(1, 3'b001, 0, 0, 0);
        c0 = cyc;
        while (cyc < c0 + 3) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1 check_all_zero("reset_mid_redir");
        @(negedge clk);
        check_all_zero("reset_held");
        #1 rst = 1'b0;
        add_services(cyc);
        drain(50);

        // randomized mixes
        for (int i = 0; i < 40; i++) begin
            set_ctx($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            SRR0_in = $urandom; SRR1_in = $urandom;
            apply($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            drain(100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
